// File: rtl/local_maxima_peak_reader_pkg.sv
// Shared geometry and state encoding for the local-maxima peak reader.
// The maxima engine imports the same constants so both ends agree on the
// frame size and on the width of the coordinates they exchange.
package local_maxima_peak_reader_pkg;

  // Default frame geometry.
  localparam int LM_ROWS  = 6;
  localparam int LM_COLS  = 6;

  // Pixel index / peak counter width; 2**LM_IDX_W must exceed NPIX so an
  // all-ones frame can be counted without wrapping.
  localparam int LM_IDX_W = 6;

  // Width of the 1-based row and col coordinates.
  localparam int LM_CRD_W = 3;

  // Pixels per frame and the index of the last pixel.
  localparam int NPIX     = LM_ROWS * LM_COLS;
  localparam int LAST_IDX = NPIX - 1;

  // Reader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SCAN    = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } lm_state_t;

endpackage

// File: rtl/local_maxima_peak_reader_coord.sv
// lm_coord_counter: 1-based row/col counter pair that walks a frame in
// row-major order. clear loads (1,1), advance steps one pixel, and last
// flags the bottom-right pixel. Reset parks both counters at 0, which is
// never a valid coordinate, until the first clear.
module lm_coord_counter
  import local_maxima_peak_reader_pkg::*;
#(
  parameter int ROWS  = LM_ROWS,
  parameter int COLS  = LM_COLS,
  parameter int CRD_W = LM_CRD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [CRD_W-1:0] row,
  output logic [CRD_W-1:0] col,
  output logic             last
);

  localparam logic [CRD_W-1:0] ROW_MAX = CRD_W'(ROWS);
  localparam logic [CRD_W-1:0] COL_MAX = CRD_W'(COLS);
  localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);

  logic [CRD_W-1:0] row_q;
  logic [CRD_W-1:0] col_q;

  // Column counts 1..COLS; wrapping it moves to the next row.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clear) begin
      row_q <= CRD_ONE;
      col_q <= CRD_ONE;
    end else if (advance) begin
      if (col_q == COL_MAX) begin
        col_q <= CRD_ONE;
        if (row_q == ROW_MAX) begin
          row_q <= CRD_ONE;
        end else begin
          row_q <= row_q + CRD_ONE;
        end
      end else begin
        col_q <= col_q + CRD_ONE;
      end
    end
  end

  // Bottom-right pixel of the frame.
  always_comb begin
    last = (row_q == ROW_MAX) && (col_q == COL_MAX);
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/local_maxima_peak_reader.sv
// local_maxima_peak_reader: captures one ROWS x COLS local-maxima mask
// frame (one bit per pixel, row-major), then walks it and emits the 1-based
// (row, col) of every set bit, finishing with a one-cycle done pulse and
// the number of peaks emitted.
//
// Peak handshake: peak_valid rises on entry to EMIT with peak_row/peak_col
// already registered; a transfer happens on every rising clk edge where
// peak_valid && peak_ready. While peak_ready is low, peak_valid stays high
// and the coordinate does not change; only rst can drop peak_valid without
// a transfer.
module local_maxima_peak_reader
  import local_maxima_peak_reader_pkg::*;
#(
  parameter int ROWS  = LM_ROWS,
  parameter int COLS  = LM_COLS,
  parameter int IDX_W = LM_IDX_W,
  parameter int CRD_W = LM_CRD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [CRD_W-1:0] peak_row,
  output logic [CRD_W-1:0] peak_col,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] peak_count
);

  localparam int               PIX_N    = ROWS * COLS;
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(PIX_N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  lm_state_t        state_q;
  lm_state_t        state_d;

  logic [PIX_N-1:0] mask_q;
  logic [IDX_W-1:0] cap_idx_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic [IDX_W-1:0] cnt_q;
  logic [CRD_W-1:0] peak_row_q;
  logic [CRD_W-1:0] peak_col_q;
  logic [IDX_W-1:0] peak_count_q;
  logic             done_q;

  // Strobes decoded from the FSM for the datapath and coordinate counter.
  logic             cap_we;
  logic             cap_last;
  logic             scan_hit;
  logic             scan_step;
  logic             emit_hs;
  logic             crd_clear;
  logic             crd_adv;

  logic             mask_bit;
  logic [CRD_W-1:0] crd_row;
  logic [CRD_W-1:0] crd_col;
  logic             crd_last;

  // Row/col of the pixel currently under scan, in lockstep with scan_idx.
  lm_coord_counter #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .CRD_W (CRD_W)
  ) u_coord (
    .clk     (clk),
    .rst     (rst),
    .clear   (crd_clear),
    .advance (crd_adv),
    .row     (crd_row),
    .col     (crd_col),
    .last    (crd_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, datapath strobes and the state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    cap_we     = 1'b0;
    cap_last   = 1'b0;
    scan_hit   = 1'b0;
    scan_step  = 1'b0;
    emit_hs    = 1'b0;
    crd_clear  = 1'b0;
    crd_adv    = 1'b0;
    peak_valid = 1'b0;
    busy       = 1'b1;
    mask_bit   = mask_q[scan_idx_q];

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (bit_valid) begin
          cap_we = 1'b1;
          if (cap_idx_q == PIX_LAST) begin
            cap_last  = 1'b1;
            crd_clear = 1'b1;
            state_d   = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        if (mask_bit) begin
          scan_hit = 1'b1;
          state_d  = ST_EMIT;
        end else if (crd_last) begin
          state_d  = ST_DONE;
        end else begin
          scan_step = 1'b1;
          crd_adv   = 1'b1;
        end
      end

      ST_EMIT: begin
        peak_valid = 1'b1;
        if (peak_ready) begin
          emit_hs = 1'b1;
          if (crd_last) begin
            state_d = ST_DONE;
          end else begin
            crd_adv = 1'b1;
            state_d = ST_SCAN;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Mask capture, scan/emit bookkeeping and the registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q       <= '0;
      cap_idx_q    <= '0;
      scan_idx_q   <= '0;
      cnt_q        <= '0;
      peak_row_q   <= '0;
      peak_col_q   <= '0;
      peak_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if ((state_q == ST_IDLE) && start) begin
        cap_idx_q <= '0;
        cnt_q     <= '0;
      end

      if (cap_we) begin
        mask_q[cap_idx_q] <= bit_in;
        cap_idx_q         <= cap_idx_q + IDX_ONE;
      end

      if (cap_last) begin
        scan_idx_q <= '0;
      end

      // Coordinates are latched on the SCAN cycle so they are already
      // stable when peak_valid rises in EMIT.
      if (scan_hit) begin
        peak_row_q <= crd_row;
        peak_col_q <= crd_col;
      end

      if (scan_step) begin
        scan_idx_q <= scan_idx_q + IDX_ONE;
      end

      if (emit_hs) begin
        cnt_q      <= cnt_q + IDX_ONE;
        scan_idx_q <= scan_idx_q + IDX_ONE;
      end

      // The DONE cycle publishes the count; done is seen alongside it.
      if (state_q == ST_DONE) begin
        done_q       <= 1'b1;
        peak_count_q <= cnt_q;
      end
    end
  end

  assign peak_row   = peak_row_q;
  assign peak_col   = peak_col_q;
  assign peak_count = peak_count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_local_maxima_peak_reader.sv
// Bench for local_maxima_peak_reader: directed frames from the test plan
// plus random frames, checked against a list of expected peaks computed
// directly from the mask with division and modulo.
module tb_local_maxima_peak_reader;

  localparam int ROWS  = 6;
  localparam int COLS  = 6;
  localparam int IDX_W = 6;
  localparam int CRD_W = 3;
  localparam int NPIX  = ROWS * COLS;

  logic             clk;
  logic             rst;
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             peak_valid;
  logic             peak_ready;
  logic [CRD_W-1:0] peak_row;
  logic [CRD_W-1:0] peak_col;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] peak_count;

  // Expected peaks in emission order, packed as {row, col}.
  logic [2*CRD_W-1:0] exp_q[$];

  int n_checks;
  int n_pass;

  local_maxima_peak_reader #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .IDX_W (IDX_W),
    .CRD_W (CRD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .peak_valid (peak_valid),
    .peak_ready (peak_ready),
    .peak_row   (peak_row),
    .peak_col   (peak_col),
    .busy       (busy),
    .done       (done),
    .peak_count (peak_count)
  );

  // Clock and a hard time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: every set pixel, in index order, at (i/COLS+1, i%COLS+1).
  task automatic build_model(input logic [NPIX-1:0] m);
    logic [CRD_W-1:0] r;
    logic [CRD_W-1:0] c;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      if (m[i]) begin
        r = CRD_W'(i / COLS + 1);
        c = CRD_W'(i % COLS + 1);
        exp_q.push_back({r, c});
      end
    end
  endtask

  // Pulse start, then feed the frame; stall toggles bit_valid every cycle.
  task automatic capture_frame(input logic [NPIX-1:0] m, input bit stall, input bit extra_start);
    int idx;
    int guard;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    guard = 0;
    while (idx < NPIX && guard < 1000) begin
      bit_valid = stall ? (guard % 2 == 1) : 1'b1;
      bit_in    = bit_valid ? m[idx] : 1'($urandom_range(0, 1));
      start     = extra_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      if (bit_valid) idx++;
      guard++;
    end
    start     = 1'b0;
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
  endtask

  // Collect peaks until done. bp_mode: 0 ready high, 1 random ready,
  // 2 ready held low for the first 5 valid cycles.
  task automatic drain(input int bp_mode, input bit extra_start);
    int k;
    int npk;
    int lat_exp;
    int hold;
    bit prev_stall;
    bit seen_done;
    logic [CRD_W-1:0] prev_row;
    logic [CRD_W-1:0] prev_col;
    logic [2*CRD_W-1:0] e;
    npk        = exp_q.size();
    lat_exp    = NPIX + 1 + npk;
    k          = 0;
    hold       = 0;
    prev_stall = 1'b0;
    seen_done  = 1'b0;
    prev_row   = '0;
    prev_col   = '0;
    while (!seen_done && k < 2000) begin
      if (prev_stall) begin
        check("hold_valid", peak_valid, 1);
        check("hold_row", peak_row, prev_row);
        check("hold_col", peak_col, prev_col);
      end
      if (done) begin
        seen_done = 1'b1;
        check("peak_count", peak_count, npk);
        check("leftover_peaks", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        if (bp_mode == 0) check("done_latency", k, lat_exp);
      end else begin
        check("busy", busy, 1);
        bit_valid = 1'($urandom_range(0, 1));
        bit_in    = 1'($urandom_range(0, 1));
        start     = extra_start ? ($urandom_range(0, 3) == 0) : 1'b0;
        case (bp_mode)
          0:       peak_ready = 1'b1;
          1:       peak_ready = ($urandom_range(0, 2) != 0);
          default: peak_ready = (hold >= 5);
        endcase
        if (peak_valid && !peak_ready) hold++;
        if (peak_valid && peak_ready) begin
          check("peak_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("peak_row", peak_row, e[2*CRD_W-1:CRD_W]);
            check("peak_col", peak_col, e[CRD_W-1:0]);
          end
        end
        prev_stall = peak_valid && !peak_ready;
        prev_row   = peak_row;
        prev_col   = peak_col;
        @(negedge clk);
        k++;
      end
    end
    start      = 1'b0;
    bit_valid  = 1'b0;
    peak_ready = 1'b0;
    check("done_seen", seen_done, 1);
    if (seen_done) begin
      @(negedge clk);
      check("done_pulse_width", done, 0);
    end
  endtask

  task automatic run_frame(input logic [NPIX-1:0] m, input bit stall, input int bp_mode, input bit extra_start);
    build_model(m);
    capture_frame(m, stall, extra_start);
    drain(bp_mode, extra_start);
  endtask

  // Main sequence.
  initial begin
    logic [NPIX-1:0] m;
    int w;
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    peak_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_peak_row", peak_row, 0);
    check("rst_peak_col", peak_col, 0);
    check("rst_peak_count", peak_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero frame.
    run_frame('0, 1'b0, 0, 1'b0);

    // Single peak at index 7 -> (2,2).
    m = '0; m[7] = 1'b1;
    run_frame(m, 1'b0, 0, 1'b0);

    // Four corners.
    m = '0; m[0] = 1'b1; m[5] = 1'b1; m[30] = 1'b1; m[35] = 1'b1;
    run_frame(m, 1'b0, 0, 1'b0);

    // Backpressure on a single peak at index 14 -> (3,3).
    m = '0; m[14] = 1'b1;
    run_frame(m, 1'b0, 2, 1'b0);

    // All-ones frame.
    m = '1;
    run_frame(m, 1'b0, 0, 1'b0);

    // Capture stalls with extra start pulses during capture and emit.
    m = NPIX'({$urandom, $urandom});
    run_frame(m, 1'b1, 1, 1'b1);

    // Random frames of varying density and backpressure.
    for (int f = 0; f < 8; f++) begin
      w = $urandom_range(0, 2);
      m = NPIX'({$urandom, $urandom});
      if (w == 0) m = m & NPIX'({$urandom, $urandom});
      if (w == 2) m = m | NPIX'({$urandom, $urandom});
      run_frame(m, 1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    // Reset while a peak waits in EMIT, with start asserted alongside rst.
    m = '0; m[14] = 1'b1; m[20] = 1'b1;
    build_model(m);
    capture_frame(m, 1'b0, 1'b0);
    bit_valid  = 1'b0;
    peak_ready = 1'b0;
    for (int i = 0; i < 100 && !peak_valid; i++) @(negedge clk);
    check("reach_emit", peak_valid, 1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_peak_valid", peak_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_abort_busy", busy, 0);
      check("post_abort_done", done, 0);
    end

    // A clean frame after the abort.
    m = '0; m[3] = 1'b1; m[17] = 1'b1; m[29] = 1'b1;
    run_frame(m, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/local_maxima_peak_reader.md
Name: local_maxima_peak_reader

Overview:
- Consumer at the far end of the local-maxima engine's 1-bit result stream.
- Captures one ROWS x COLS mask frame, supplied one bit per pixel in row-major order.
- Walks the stored mask and emits the (row, col) coordinates of every set bit over a valid/ready handshake, then reports the total peak count.
- Sits between the maxima engine and downstream consumers such as a host readout or a peak-list FIFO.

Parameters:
- ROWS, 6, image height in pixels.
- COLS, 6, image width in pixels.
- IDX_W, 6, width of the pixel index and peak counter. Must satisfy 2^IDX_W > ROWS*COLS.
- CRD_W, 3, width of the row and col coordinate outputs. Coordinates are 1-based.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse that arms capture of a new frame.
- bit_in  in  1  result bit for the current pixel (1 = local maximum).
- bit_valid  in  1  bit_in is meaningful this cycle.
- peak_valid  out  1  peak_row/peak_col hold a valid peak coordinate.
- peak_ready  in  1  downstream accepts the coordinate.
- peak_row  out  CRD_W  row of the peak, 1..ROWS.
- peak_col  out  CRD_W  column of the peak, 1..COLS.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse marking the end of the peak list.
- peak_count  out  IDX_W  number of peaks emitted in the last frame; stable until the next done.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high. While rst is high at a clk edge, the block enters IDLE.
  - On reset, the mask and all counters clear to 0, and peak_valid, busy, done, peak_row, peak_col and peak_count all reset to 0.
  - Reset mid-operation (any state) aborts the frame. No partial done is produced.
- FSM states: IDLE, CAPTURE, SCAN, EMIT, DONE.
- IDLE:
  - start=1 sets cap_idx=0 and a running counter cnt=0, then moves to CAPTURE.
  - bit_valid is ignored in IDLE.
- CAPTURE:
  - Each cycle with bit_valid=1 writes mask[cap_idx]=bit_in and increments cap_idx.
  - bit_valid=0 stalls capture with no change.
  - When the bit at index ROWS*COLS-1 is written, set scan_idx=0 and move to SCAN on the next cycle.
  - Bits beyond the frame never arrive in CAPTURE; any bit_valid seen in later states is ignored.
- SCAN (one index per cycle):
  - If mask[scan_idx]=1, move to EMIT. peak_row = scan_idx/COLS+1 and peak_col = scan_idx%COLS+1 are registered so they are valid on EMIT entry.
  - If mask[scan_idx]=0 and scan_idx=ROWS*COLS-1, move to DONE.
  - Otherwise increment scan_idx.
- EMIT:
  - peak_valid=1. peak_row and peak_col are held stable while peak_ready=0.
  - The handshake is peak_valid & peak_ready. On handshake: cnt increments, peak_valid drops, scan_idx increments.
  - After the handshake, go to DONE if scan_idx was the last index, otherwise return to SCAN.
  - peak_valid is never deasserted without a handshake, except on rst.
- DONE:
  - For exactly one cycle: done=1 and peak_count<=cnt. Then return to IDLE.
  - start is ignored in every state other than IDLE, including DONE.
- Timing and arithmetic:
  - Latency: with peak_ready tied high and no set bits, done asserts ROWS*COLS+1 cycles after the last captured bit.
  - Each peak costs 2 cycles (one SCAN cycle plus one EMIT cycle) under zero backpressure.
  - All arithmetic is unsigned.
  - Row/col conversion uses row and col counters that advance with scan_idx, not a divider. col wraps COLS -> 1, and row increments on that wrap.
- Boundary cases:
  - All-zero frame: peak_count=0 and done still pulses.
  - All-ones frame: peak_count=ROWS*COLS, with no counter overflow because 2^IDX_W > ROWS*COLS.
  - A start pulse in the same cycle as rst is ignored.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Constants NPIX=ROWS*COLS and LAST_IDX=NPIX-1.
  - Coordinate width, so the maxima engine and this block agree on geometry.
- One natural sub-module, lm_coord_counter: a row/col counter pair with clear, advance and a last-pixel flag. Used by SCAN and reusable by the pixel source on the engine's input side.
- The mask register and FSM stay in the top-level module.

Test Plan:
- All-zero frame: start, then 36 zero bits with bit_valid=1 -> peak_valid never asserts; done pulses once with peak_count=0, 37 cycles after the last bit.
- Single peak at index 7: peak_valid asserts with peak_row=2, peak_col=2; peak_ready=1 -> done pulses with peak_count=1.
- Corners: bits set at indices 0, 5, 30, 35 -> peaks in order (1,1), (1,6), (6,1), (6,6); peak_count=4.
- Backpressure: one peak at index 14 with peak_ready held low for 5 cycles -> peak_valid stays high and (3,3) holds stable; exactly one handshake; done follows.
- Capture stalls and ignored start: bit_valid toggled every other cycle, extra start pulses in CAPTURE and EMIT -> mask is captured correctly and the frame is neither restarted nor corrupted.
- Reset mid-operation: rst during EMIT -> next cycle peak_valid=0, busy=0, done never pulses; a new start frame then completes normally with the correct count.
